// File: rtl/qlf_k4n8_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module  : qlf_k4n8_cfg_loader
// Purpose : Configuration frame loader for the K4N8 logic-cell scan chain.
//           Accepts config words over a valid/ready stream and serialises
//           exactly CHAIN_LEN bits, LSB first, onto the chain head. It then
//           pulses cfg_latch for one cycle so the cells capture the frame.
// Ports   : C         - clock, all state updates on posedge
//           R         - synchronous reset, active-high
//           start     - begin a frame (honoured only when idle or done)
//           in_data   - config word, bit 0 shifted first
//           in_valid  - in_data valid
//           in_ready  - loader accepts in_data this cycle
//           scan_d    - serial bit to chain head
//           scan_en   - chain shift enable
//           cfg_latch - one-cycle capture pulse after the last bit
//           busy      - frame in progress (LOAD, SHIFT, LATCH)
//           done      - frame complete; cleared by the next accepted start
// Revision: 1.0 - initial release
// ============================================================================
module qlf_k4n8_cfg_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 128,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              C,
  input  logic              R,
  input  logic              start,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              scan_d,
  output logic              scan_en,
  output logic              cfg_latch,
  output logic              busy,
  output logic              done
);

  localparam int WB_W = $clog2(WORD_W + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_LATCH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bits_left_q, bits_left_d;
  logic [WB_W-1:0]   word_bits_q, word_bits_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic              scan_d_q, scan_en_q, cfg_latch_q;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    bits_left_d = bits_left_q;
    word_bits_d = word_bits_q;
    sreg_d      = sreg_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_LOAD;
          bits_left_d = CNT_W'(CHAIN_LEN);
        end
      end

      S_LOAD: begin
        // in_ready is high throughout LOAD, so in_valid alone is the handshake
        if (in_valid) begin
          sreg_d      = in_data;
          word_bits_d = WB_W'(WORD_W);
          state_d     = S_SHIFT;
        end
      end

      S_SHIFT: begin
        sreg_d = sreg_q >> 1;
        if (word_bits_q != '0) word_bits_d = word_bits_q - WB_W'(1);
        if (bits_left_q != '0) bits_left_d = bits_left_q - CNT_W'(1);
        // Frame end takes priority: leftover upper bits of a partial word
        // are simply dropped.
        if (bits_left_q <= CNT_W'(1)) begin
          state_d = S_LATCH;
        end else if (word_bits_q <= WB_W'(1)) begin
          state_d = S_LOAD;
        end
      end

      S_LATCH: state_d = S_DONE;

      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State and output registers. The scan outputs are computed from the next
  // state so they line up with the state they belong to while staying flops.
  // --------------------------------------------------------------------------
  always_ff @(posedge C) begin
    if (R) begin
      state_q     <= S_IDLE;
      bits_left_q <= '0;
      word_bits_q <= '0;
      sreg_q      <= '0;
      scan_d_q    <= 1'b0;
      scan_en_q   <= 1'b0;
      cfg_latch_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bits_left_q <= bits_left_d;
      word_bits_q <= word_bits_d;
      sreg_q      <= sreg_d;
      scan_en_q   <= (state_d == S_SHIFT);
      scan_d_q    <= (state_d == S_SHIFT) ? sreg_d[0] : 1'b0;
      cfg_latch_q <= (state_d == S_LATCH);
    end
  end

  assign scan_d    = scan_d_q;
  assign scan_en   = scan_en_q;
  assign cfg_latch = cfg_latch_q;
  assign in_ready  = (state_q == S_LOAD);
  assign busy      = (state_q == S_LOAD) || (state_q == S_SHIFT) ||
                     (state_q == S_LATCH);
  assign done      = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_qlf_k4n8_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_qlf_k4n8_cfg_loader
// Purpose : Self-checking bench for qlf_k4n8_cfg_loader. Three instances
//           (CHAIN_LEN 16, 12 and 1) share one stimulus stream; each is
//           checked every cycle against a queue-based frame model, and
//           directed scenarios add hand-computed literal expectations.
// Revision: 1.0 - initial release
// ============================================================================
module tb_qlf_k4n8_cfg_loader;

  localparam int W = 8;
  localparam int N = 3;
  int LEN [N] = '{16, 12, 1};

  logic         C = 1'b0;
  logic         R, start, in_valid;
  logic [W-1:0] in_data;
  logic [N-1:0] rdy, sd, sen, lat, bsy, dn;

  always #5 C = ~C;

  qlf_k4n8_cfg_loader #(.WORD_W(W), .CHAIN_LEN(16)) u_l16 (
    .C(C), .R(R), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[0]), .scan_d(sd[0]), .scan_en(sen[0]), .cfg_latch(lat[0]),
    .busy(bsy[0]), .done(dn[0]));

  qlf_k4n8_cfg_loader #(.WORD_W(W), .CHAIN_LEN(12)) u_l12 (
    .C(C), .R(R), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[1]), .scan_d(sd[1]), .scan_en(sen[1]), .cfg_latch(lat[1]),
    .busy(bsy[1]), .done(dn[1]));

  qlf_k4n8_cfg_loader #(.WORD_W(W), .CHAIN_LEN(1)) u_l1 (
    .C(C), .R(R), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[2]), .scan_d(sd[2]), .scan_en(sen[2]), .cfg_latch(lat[2]),
    .busy(bsy[2]), .done(dn[2]));

  int total = 0;
  int bad   = 0;
  bit check_on = 0;
  int cyc = 0;

  // ---------------- frame model ----------------
  // Accepted words become a queue of pending chain bits (truncated at the
  // frame length); one bit leaves per cycle. Empty queue with the frame
  // incomplete means "waiting for a word"; complete means capture, then done.
  bit bq [N][$];
  int queued [N];
  bit act [N], lpend [N], mdone [N];

  // observation for literal checks
  bit cap [N][$];
  int nlat [N], nacc [N], nsh [N];

  function automatic bit e_en(int i);
    return bq[i].size() > 0;
  endfunction
  function automatic bit e_d(int i);
    return (bq[i].size() > 0) ? bq[i][0] : 1'b0;
  endfunction
  function automatic bit e_rdy(int i);
    return act[i] && (bq[i].size() == 0) && !lpend[i] && (queued[i] < LEN[i]);
  endfunction

  always @(posedge C) begin
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (rdy[i] && in_valid) nacc[i]++;
      if (sen[i]) nsh[i]++;
      if (R) begin
        bq[i].delete();
        queued[i] = 0; act[i] = 0; lpend[i] = 0; mdone[i] = 0;
      end else begin
        bit en0, rd0, lp0, a0;
        en0 = e_en(i); rd0 = e_rdy(i); lp0 = lpend[i]; a0 = act[i];
        if (en0) begin
          void'(bq[i].pop_front());
          if (bq[i].size() == 0 && queued[i] == LEN[i]) lpend[i] = 1;
        end
        if (lp0) begin
          lpend[i] = 0; act[i] = 0; mdone[i] = 1;
        end
        if (rd0 && in_valid) begin
          for (int b = 0; b < W; b++) begin
            if (queued[i] < LEN[i]) begin
              bq[i].push_back(in_data[b]);
              queued[i]++;
            end
          end
        end
        if (!a0 && start) begin
          act[i] = 1; queued[i] = 0; mdone[i] = 0;
        end
      end
    end
  end

  task automatic chk(string nm, int i, logic a, logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s[%0d] got=%b exp=%b t=%0t", nm, i, a, e, $time);
    end
  endtask

  task automatic chk_int(string nm, int a, int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, a, e, $time);
    end
  endtask

  // per-cycle compare, away from the active edge
  always @(negedge C) begin
    if (check_on) begin
      for (int i = 0; i < N; i++) begin
        chk("in_ready",  i, rdy[i], e_rdy(i));
        chk("scan_en",   i, sen[i], e_en(i));
        chk("scan_d",    i, sd[i],  e_d(i));
        chk("cfg_latch", i, lat[i], lpend[i]);
        chk("busy",      i, bsy[i], act[i]);
        chk("done",      i, dn[i],  mdone[i]);
        if (sen[i]) cap[i].push_back(sd[i]);
        if (lat[i]) nlat[i]++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int seq1 [16] = '{1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0};
  int sedge;

  task automatic clear_obs();
    for (int i = 0; i < N; i++) begin
      cap[i].delete(); nlat[i] = 0; nacc[i] = 0; nsh[i] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge C) R = 1'b1;
    @(negedge C) R = 1'b0;
    clear_obs();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    sedge = cyc + 1;
    @(negedge C) start = 1'b0;
  endtask

  task automatic wait_ready(int i);
    int n = 0;
    while (!rdy[i] && n < 60) begin @(negedge C); n++; end
    if (!rdy[i]) begin bad++; total++; $display("FAIL wait_ready[%0d] got=timeout exp=ready", i); end
  endtask

  task automatic push(int i, logic [W-1:0] w);
    wait_ready(i);
    in_data = w; in_valid = 1'b1;
    @(negedge C) in_valid = 1'b0;
  endtask

  task automatic wait_done(int i);
    int n = 0;
    while (!dn[i] && n < 200) begin @(negedge C); n++; end
    if (!dn[i]) begin bad++; total++; $display("FAIL wait_done[%0d] got=timeout exp=done", i); end
  endtask

  task automatic chk_seq16(string nm);
    chk_int({nm, "_len"}, cap[0].size(), 16);
    for (int k = 0; k < 16 && k < cap[0].size(); k++)
      chk_int({nm, "_bit"}, int'(cap[0][k]), seq1[k]);
  endtask

  initial begin
    R = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge C);
    @(negedge C);
    check_on = 1;
    chk("rst_done", 0, dn[0], 1'b0);
    chk("rst_scan_en", 0, sen[0], 1'b0);
    chk("rst_ready", 0, rdy[0], 1'b0);
    R = 1'b0;
    clear_obs();

    // 1: basic 16-bit frame, words back to back
    do_reset();
    pulse_start();
    push(0, 8'hA5);
    push(0, 8'h3C);
    wait_done(0);
    chk_int("s1_done_edges", cyc - sedge, 19);
    chk_seq16("s1");
    chk_int("s1_latches", nlat[0], 1);

    // 2: 5-cycle valid gap between words
    do_reset();
    pulse_start();
    push(0, 8'hA5);
    wait_ready(0);
    repeat (5) @(negedge C);
    chk("s2_gap_ready", 0, rdy[0], 1'b1);
    chk("s2_gap_en", 0, sen[0], 1'b0);
    push(0, 8'h3C);
    wait_done(0);
    chk_seq16("s2");
    chk_int("s2_latches", nlat[0], 1);

    // 3: 12-bit chain, second word partially used
    do_reset();
    pulse_start();
    push(1, 8'hFF);
    push(1, 8'h0F);
    wait_done(1);
    in_data = 8'h55; in_valid = 1'b1;
    repeat (3) @(negedge C);
    in_valid = 1'b0;
    chk_int("s3_len", cap[1].size(), 12);
    for (int k = 0; k < cap[1].size(); k++) chk_int("s3_bit", int'(cap[1][k]), 1);
    chk_int("s3_words", nacc[1], 2);
    chk_int("s3_latches", nlat[1], 1);

    // 4: reset while shifting bit 7, then a clean frame
    do_reset();
    pulse_start();
    push(0, 8'hA5);
    begin
      int n = 0;
      while (!(nsh[0] == 6 && sen[0]) && n < 40) begin @(negedge C); n++; end
      chk_int("s4_reach_bit7", nsh[0], 6);
    end
    R = 1'b1;
    @(negedge C) R = 1'b0;
    chk("s4_scan_en", 0, sen[0], 1'b0);
    chk("s4_busy", 0, bsy[0], 1'b0);
    chk("s4_ready", 0, rdy[0], 1'b0);
    chk("s4_scan_d", 0, sd[0], 1'b0);
    repeat (3) @(negedge C);
    chk_int("s4_no_latch", nlat[0], 0);
    clear_obs();
    pulse_start();
    push(0, 8'hA5);
    push(0, 8'h3C);
    wait_done(0);
    chk_seq16("s4");

    // 5: start ignored mid-frame, restart from DONE
    do_reset();
    pulse_start();
    push(0, 8'hA5);
    repeat (3) begin
      start = 1'b1; @(negedge C);
      start = 1'b0; @(negedge C);
    end
    push(0, 8'h3C);
    wait_done(0);
    chk_seq16("s5a");
    clear_obs();
    pulse_start();
    chk("s5_done_clr", 0, dn[0], 1'b0);
    chk("s5_ready", 0, rdy[0], 1'b1);
    push(0, 8'hA5);
    push(0, 8'h3C);
    wait_done(0);
    chk_seq16("s5b");
    chk_int("s5_latches", nlat[0], 1);

    // 6: single-bit chain
    do_reset();
    pulse_start();
    push(2, 8'h02);
    wait_done(2);
    chk_int("s6_len", cap[2].size(), 1);
    if (cap[2].size() > 0) chk_int("s6_bit", int'(cap[2][0]), 0);
    chk_int("s6_latches", nlat[2], 1);

    repeat (2) @(negedge C);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
